vx_barrier_unit: RTL and testbench
==================================

// Module: vx_barrier_unit
// PURPOSE
//  Warp barrier controller directly downstream of the gpu_barrier_t request issued by the GPU unit.
//  Records warp arrivals per barrier ID and holds arrived warps in a stall mask.
//  Releases all participants together once the barrier's (size_m1+1)-th distinct warp arrives.
//  Feeds the warp scheduler, which ANDs ~stall_mask into its active-warp selection.
// PARAMETERS
//  NUM_WARPS     4   warps per core; NW_BITS = UP(CLOG2(NUM_WARPS))
//  NUM_BARRIERS  4   barrier IDs; NB_BITS = UP(CLOG2(NUM_BARRIERS))
// PORTS
//  clk            in   1          core clock
//  reset          in   1          synchronous, active-high
//  bar_valid      in   1          barrier request strobe (gpu_barrier_t.valid); 1 req/cycle max
//  bar_wid        in   NW_BITS    requesting warp
//  bar_id         in   NB_BITS    barrier ID (gpu_barrier_t.id)
//  bar_size_m1    in   NW_BITS    participant count minus one (gpu_barrier_t.size_m1)
//  warp_flush     in   NUM_WARPS  warps being killed; removed from every barrier
//  stall_mask     out  NUM_WARPS  warps currently waiting at any barrier (registered)
//  release_valid  out  1          one-cycle pulse: a barrier completed (registered)
//  release_id     out  NB_BITS    completed barrier ID, valid with release_valid
//  release_mask   out  NUM_WARPS  warps released, valid with release_valid
// BEHAVIOUR
//  State per barrier b: busy[b], size[b] (NW_BITS), cnt[b] (NW_BITS), mask[b] (NUM_WARPS).
//  Reset: all busy/cnt/mask/size = 0; stall_mask=0, release_valid=0, release_id=0, release_mask=0.
//  Barrier FSM per ID: IDLE --first arrival, size_m1>0--> WAIT --last arrival--> IDLE.
//  Request in cycle N (bar_valid=1, b=bar_id, w=bar_wid):
//   - IDLE and size_m1==0: release immediately; release_mask=(1<<w); no stall; stays IDLE.
//   - IDLE and size_m1>0: busy=1, size=size_m1 (latched), cnt=1, mask=(1<<w).
//   - WAIT, w already in mask[b]: ignored (no count change, no release).
//   - WAIT, cnt[b]==size[b]: release; release_mask=mask[b]|(1<<w); clear busy/cnt/mask.
//   - WAIT otherwise: cnt+=1, mask|=(1<<w); bar_size_m1 ignored (first arrival's size wins).
//  Latency: all effects visible at N+1 (stall bit set, or release pulse + stall bits cleared).
//  release_valid high exactly one cycle per completion; 0 in all other cycles.
//  stall_mask = OR over b of mask[b], registered (equals next-state masks).
//  warp_flush[w] in cycle N: bit w cleared from every mask[b], cnt[b] decremented where set;
//   barrier whose mask becomes 0 returns to IDLE (busy=0). Flush never triggers a release.
//  Flush and request for the same warp in the same cycle: flush wins, request dropped.
//  Flush of other warps + request same cycle: flush applied first, then request evaluated
//   against post-flush cnt/mask.
//  cnt never exceeds size_m1 (max NUM_WARPS-1); no wrap-around possible.
//  A warp waits on at most one barrier (it is stalled); the scheduler guarantees no second request.
//  Reset mid-operation: all barriers drop to IDLE, stall_mask=0, no release pulse in the following cycle.
// TESTING
//  T1 reset: assert reset 2 cycles -> stall_mask=0, release_valid=0, release_mask=0.
//  T2 solo: bar id=1, wid=2, size_m1=0 -> next cycle release_valid=1, id=1, mask=4'b0100, stall=0.
//  T3 full barrier: id=0, size_m1=3, wids 0,1,2 over 3 cycles -> stall 0001,0011,0111; wid 3 ->
//     release_mask=1111, stall_mask=0000 the same cycle, release_valid low the next.
//  T4 duplicate: id=2 size_m1=1, wid 1 twice -> no release, stall=0010; wid 3 -> release 1010.
//  T5 interleave: id0 (size_m1=1) wid0; id1 (size_m1=1) wid1; id1 wid2 -> release id=1, mask=0110,
//     stall=0001; id0 wid3 -> release id=0, mask=1001.
//  T6 flush: id0 size_m1=2, wids 0,1 arrive; warp_flush=0010 -> stall=0001, cnt=1;
//     wid 1 and 2 arrive -> release mask=0111.

Source files
------------

// File: rtl/vx_barrier_unit.sv
// Warp barrier controller: tracks warp arrivals per barrier ID, stalls arrived warps,
// and releases all participants together when the last expected warp arrives.
module vx_barrier_unit #(
    parameter int NUM_WARPS    = 4,
    parameter int NUM_BARRIERS = 4,
    parameter int NW_BITS      = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
    parameter int NB_BITS      = (NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 bar_valid,
    input  logic [NW_BITS-1:0]   bar_wid,
    input  logic [NB_BITS-1:0]   bar_id,
    input  logic [NW_BITS-1:0]   bar_size_m1,
    input  logic [NUM_WARPS-1:0] warp_flush,
    output logic [NUM_WARPS-1:0] stall_mask,
    output logic                 release_valid,
    output logic [NB_BITS-1:0]   release_id,
    output logic [NUM_WARPS-1:0] release_mask
);

    typedef enum logic {
        BAR_IDLE = 1'b0,
        BAR_WAIT = 1'b1
    } bar_state_e;

    localparam logic [NW_BITS-1:0] ONE_CNT = NW_BITS'(1);

    bar_state_e           state_q [NUM_BARRIERS];
    bar_state_e           state_d [NUM_BARRIERS];
    logic [NW_BITS-1:0]   size_q  [NUM_BARRIERS];
    logic [NW_BITS-1:0]   size_d  [NUM_BARRIERS];
    logic [NW_BITS-1:0]   cnt_q   [NUM_BARRIERS];
    logic [NW_BITS-1:0]   cnt_d   [NUM_BARRIERS];
    logic [NUM_WARPS-1:0] mask_q  [NUM_BARRIERS];
    logic [NUM_WARPS-1:0] mask_d  [NUM_BARRIERS];

    logic [NUM_WARPS-1:0] req_bit;
    logic [NUM_WARPS-1:0] stall_d;
    logic                 rel_valid_d;
    logic [NB_BITS-1:0]   rel_id_d;
    logic [NUM_WARPS-1:0] rel_mask_d;

    // NOTE: every variable gets a default before any branch so no path leaves it unassigned (no latches).
    always_comb begin
        state_d     = state_q;
        size_d      = size_q;
        cnt_d       = cnt_q;
        mask_d      = mask_q;
        rel_valid_d = 1'b0;
        rel_id_d    = '0;
        rel_mask_d  = '0;
        stall_d     = '0;
        req_bit     = '0;
        req_bit[bar_wid] = 1'b1;

        // Flushed warps leave first, so a same-cycle request sees the post-flush barrier.
        for (int b = 0; b < NUM_BARRIERS; b++) begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                if (mask_q[b][w] && warp_flush[w]) begin
                    mask_d[b][w] = 1'b0;
                    cnt_d[b]     = cnt_d[b] - ONE_CNT;
                end
            end
            if (state_q[b] == BAR_WAIT && mask_d[b] == '0) begin
                state_d[b] = BAR_IDLE;
                cnt_d[b]   = '0;
            end
        end

        if (bar_valid && !warp_flush[bar_wid]) begin
            case (state_d[bar_id])
                BAR_IDLE: begin
                    if (bar_size_m1 == '0) begin
                        rel_valid_d = 1'b1;
                        rel_id_d    = bar_id;
                        rel_mask_d  = req_bit;
                    end else begin
                        state_d[bar_id] = BAR_WAIT;
                        size_d[bar_id]  = bar_size_m1;
                        cnt_d[bar_id]   = ONE_CNT;
                        mask_d[bar_id]  = req_bit;
                    end
                end
                BAR_WAIT: begin
                    if ((mask_d[bar_id] & req_bit) != '0) begin
                        // Repeat arrival of a waiting warp changes nothing.
                    end else if (cnt_d[bar_id] == size_d[bar_id]) begin
                        rel_valid_d     = 1'b1;
                        rel_id_d        = bar_id;
                        rel_mask_d      = mask_d[bar_id] | req_bit;
                        state_d[bar_id] = BAR_IDLE;
                        cnt_d[bar_id]   = '0;
                        mask_d[bar_id]  = '0;
                    end else begin
                        cnt_d[bar_id]  = cnt_d[bar_id] + ONE_CNT;
                        mask_d[bar_id] = mask_d[bar_id] | req_bit;
                    end
                end
                default: ;
            endcase
        end

        for (int b = 0; b < NUM_BARRIERS; b++) begin
            stall_d = stall_d | mask_d[b];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    // NOTE: the per-barrier arrays are small control state and are cleared on reset, unlike a RAM.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int b = 0; b < NUM_BARRIERS; b++) begin
                state_q[b] <= BAR_IDLE;
                size_q[b]  <= '0;
                cnt_q[b]   <= '0;
                mask_q[b]  <= '0;
            end
            stall_mask    <= '0;
            release_valid <= 1'b0;
            release_id    <= '0;
            release_mask  <= '0;
        end else begin
            for (int b = 0; b < NUM_BARRIERS; b++) begin
                state_q[b] <= state_d[b];
                size_q[b]  <= size_d[b];
                cnt_q[b]   <= cnt_d[b];
                mask_q[b]  <= mask_d[b];
            end
            stall_mask    <= stall_d;
            release_valid <= rel_valid_d;
            release_id    <= rel_id_d;
            release_mask  <= rel_mask_d;
        end
    end

endmodule

// File: tb/tb_vx_barrier_unit.sv
// Self-checking bench for vx_barrier_unit: directed scenarios plus random traffic,
// checked against a participant-list model of each barrier.
module tb_vx_barrier_unit;

    localparam int NW = 4;
    localparam int NB = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          bar_valid;
    logic [1:0]    bar_wid;
    logic [1:0]    bar_id;
    logic [1:0]    bar_size_m1;
    logic [NW-1:0] warp_flush;
    logic [NW-1:0] stall_mask;
    logic          release_valid;
    logic [1:0]    release_id;
    logic [NW-1:0] release_mask;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: the list of warps waiting at each barrier and the participant count required.
    int m_members [NB][$];
    int m_needed  [NB];

    logic          exp_rv;
    logic [1:0]    exp_id;
    logic [NW-1:0] exp_rmask;
    logic [NW-1:0] exp_stall;

    vx_barrier_unit #(.NUM_WARPS(NW), .NUM_BARRIERS(NB)) dut (
        .clk           (clk),
        .reset         (reset),
        .bar_valid     (bar_valid),
        .bar_wid       (bar_wid),
        .bar_id        (bar_id),
        .bar_size_m1   (bar_size_m1),
        .warp_flush    (warp_flush),
        .stall_mask    (stall_mask),
        .release_valid (release_valid),
        .release_id    (release_id),
        .release_mask  (release_mask)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit is_member(int b, int w);
        foreach (m_members[b][i]) if (m_members[b][i] == w) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int barrier_of(int w);
        for (int b = 0; b < NB; b++) if (is_member(b, w)) return b;
        return -1;
    endfunction

    task automatic model_clear();
        for (int b = 0; b < NB; b++) begin
            m_members[b].delete();
            m_needed[b] = 0;
        end
    endtask

    task automatic model_step(input bit v, input int w, input int b, input int sz,
                              input logic [NW-1:0] fl);
        exp_rv    = 1'b0;
        exp_id    = '0;
        exp_rmask = '0;
        for (int bb = 0; bb < NB; bb++)
            for (int i = m_members[bb].size() - 1; i >= 0; i--)
                if (fl[m_members[bb][i]]) m_members[bb].delete(i);
        if (v && !fl[w]) begin
            if (m_members[b].size() == 0) begin
                if (sz == 0) begin
                    exp_rv       = 1'b1;
                    exp_id       = 2'(b);
                    exp_rmask[w] = 1'b1;
                end else begin
                    m_members[b].push_back(w);
                    m_needed[b] = sz + 1;
                end
            end else if (!is_member(b, w)) begin
                m_members[b].push_back(w);
                if (m_members[b].size() == m_needed[b]) begin
                    exp_rv = 1'b1;
                    exp_id = 2'(b);
                    foreach (m_members[b][i]) exp_rmask[m_members[b][i]] = 1'b1;
                    m_members[b].delete();
                end
            end
        end
        exp_stall = '0;
        for (int bb = 0; bb < NB; bb++)
            foreach (m_members[bb][i]) exp_stall[m_members[bb][i]] = 1'b1;
    endtask

    task automatic cycle(input bit v, input int w, input int b, input int sz,
                         input logic [NW-1:0] fl);
        bar_valid   = v;
        bar_wid     = 2'(w);
        bar_id      = 2'(b);
        bar_size_m1 = 2'(sz);
        warp_flush  = fl;
        model_step(v, w, b, sz, fl);
        @(posedge clk);
        #1;
        check("stall_mask", 32'(stall_mask), 32'(exp_stall));
        check("release_valid", 32'(release_valid), 32'(exp_rv));
        if (exp_rv) begin
            check("release_id", 32'(release_id), 32'(exp_id));
            check("release_mask", 32'(release_mask), 32'(exp_rmask));
        end
        bar_valid  = 1'b0;
        warp_flush = '0;
    endtask

    task automatic idle();
        cycle(1'b0, 0, 0, 0, '0);
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        model_clear();
        for (int i = 0; i < cycles; i++) begin
            bar_valid   = 1'($urandom_range(0, 1));
            bar_wid     = 2'($urandom_range(0, 3));
            bar_id      = 2'($urandom_range(0, 3));
            bar_size_m1 = 2'($urandom_range(0, 3));
            warp_flush  = '0;
            @(posedge clk);
            #1;
            check("rst_stall", 32'(stall_mask), 32'h0);
            check("rst_rv", 32'(release_valid), 32'h0);
            check("rst_rmask", 32'(release_mask), 32'h0);
        end
        bar_valid = 1'b0;
        reset     = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        bar_valid   = 1'b0;
        bar_wid     = '0;
        bar_id      = '0;
        bar_size_m1 = '0;
        warp_flush  = '0;
        model_clear();

        // T1 reset
        do_reset(2);
        idle();

        // T2 solo barrier
        cycle(1'b1, 2, 1, 0, '0);
        check("t2_rv", 32'(release_valid), 32'h1);
        check("t2_id", 32'(release_id), 32'h1);
        check("t2_mask", 32'(release_mask), 32'b0100);
        check("t2_stall", 32'(stall_mask), 32'h0);
        idle();

        // T3 full barrier
        cycle(1'b1, 0, 0, 3, '0);
        check("t3_stall0", 32'(stall_mask), 32'b0001);
        cycle(1'b1, 1, 0, 3, '0);
        check("t3_stall1", 32'(stall_mask), 32'b0011);
        cycle(1'b1, 2, 0, 3, '0);
        check("t3_stall2", 32'(stall_mask), 32'b0111);
        cycle(1'b1, 3, 0, 3, '0);
        check("t3_rmask", 32'(release_mask), 32'b1111);
        check("t3_stall3", 32'(stall_mask), 32'b0000);
        idle();
        check("t3_rv_low", 32'(release_valid), 32'h0);

        // T4 duplicate arrival
        cycle(1'b1, 1, 2, 1, '0);
        cycle(1'b1, 1, 2, 1, '0);
        check("t4_norel", 32'(release_valid), 32'h0);
        check("t4_stall", 32'(stall_mask), 32'b0010);
        cycle(1'b1, 3, 2, 1, '0);
        check("t4_rmask", 32'(release_mask), 32'b1010);
        idle();

        // T5 interleaved barriers
        cycle(1'b1, 0, 0, 1, '0);
        cycle(1'b1, 1, 1, 1, '0);
        cycle(1'b1, 2, 1, 1, '0);
        check("t5_id1", 32'(release_id), 32'h1);
        check("t5_mask1", 32'(release_mask), 32'b0110);
        check("t5_stall", 32'(stall_mask), 32'b0001);
        cycle(1'b1, 3, 0, 1, '0);
        check("t5_id0", 32'(release_id), 32'h0);
        check("t5_mask0", 32'(release_mask), 32'b1001);
        idle();

        // T6 flush of a waiting warp
        cycle(1'b1, 0, 0, 2, '0);
        cycle(1'b1, 1, 0, 2, '0);
        cycle(1'b0, 0, 0, 0, 4'b0010);
        check("t6_stall", 32'(stall_mask), 32'b0001);
        cycle(1'b1, 1, 0, 2, '0);
        check("t6_norel", 32'(release_valid), 32'h0);
        cycle(1'b1, 2, 0, 2, '0);
        check("t6_rmask", 32'(release_mask), 32'b0111);
        idle();

        // Flush and request of the same warp: request is dropped
        cycle(1'b1, 3, 3, 2, 4'b1000);
        check("flush_wins", 32'(stall_mask), 32'h0);
        idle();

        // Random traffic with occasional flushes and a mid-run reset
        for (int n = 0; n < 3000; n++) begin
            int w, b, sz, home;
            logic [NW-1:0] fl;
            w    = $urandom_range(0, NW - 1);
            home = barrier_of(w);
            b    = (home >= 0) ? home : $urandom_range(0, NB - 1);
            sz   = $urandom_range(0, NW - 1);
            fl   = ($urandom_range(0, 7) == 0) ? NW'($urandom_range(0, 15)) : '0;
            cycle($urandom_range(0, 3) != 0, w, b, sz, fl);
            if (n == 1500) begin
                do_reset(1);
                idle();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
